// File: rtl/seg_pkg.sv
// seg_pkg: active-low 7-segment glyph constants and pattern-reader FSM states
package seg_pkg;
    localparam logic [6:0] SEG_0 = 7'b100_0000;
    localparam logic [6:0] SEG_1 = 7'b111_1001;
    localparam logic [6:0] SEG_2 = 7'b010_0100;
    localparam logic [6:0] SEG_3 = 7'b011_0000;
    localparam logic [6:0] SEG_4 = 7'b001_1001;
    localparam logic [6:0] SEG_5 = 7'b001_0010;
    localparam logic [6:0] SEG_6 = 7'b000_0010;
    localparam logic [6:0] SEG_7 = 7'b111_1000;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b001_0000;
    localparam logic [6:0] SEG_A = 7'b000_1000;
    localparam logic [6:0] SEG_B = 7'b000_0011;
    localparam logic [6:0] SEG_C = 7'b100_0110;
    localparam logic [6:0] SEG_D = 7'b010_0001;
    localparam logic [6:0] SEG_E = 7'b000_0110;
    localparam logic [6:0] SEG_F = 7'b000_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, MULTI} state_e;
endpackage

// File: rtl/seg_pattern_reader_if.sv
// seg_pattern_reader_if: display pins in, decoded digits and status pulses out
interface seg_pattern_reader_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digit_value;
    logic [3:0]  digit_valid;
    logic [15:0] frame_value;
    logic        frame_valid;
    logic        code_err;
    logic        an_err;
    modport master (output seg, an, input digit_value, digit_valid, frame_value, frame_valid, code_err, an_err);
    modport slave (input seg, an, output digit_value, digit_valid, frame_value, frame_valid, code_err, an_err);
endinterface

// File: rtl/seg_to_hex.sv
// seg_to_hex: inverse glyph lookup, hit low when the pattern is not a hex glyph
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble,
    output logic       hit
);
    always_comb begin
        nibble = 4'h0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_LUT[i]) begin
                nibble = 4'(i);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_pattern_reader.sv
// seg_pattern_reader: recovers hex digits from a multiplexed active-low 7-segment
// display once each digit pattern has been stable for STABLE_CYCLES cycles.
module seg_pattern_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    seg_pattern_reader_if.slave bus_io
);
    localparam int CW = $clog2(STABLE_CYCLES);
    // change detection costs one edge, so acceptance lands STABLE_CYCLES-2 counts after it
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [10:0] IN_RST = {4'hF, SEG_BLANK};

    logic [10:0] in_q, prev_q;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] val_q, val_d, frame_q, frame_d;
    logic [3:0] vld_q, vld_d, sel, nibble;
    logic fv_q, fv_d, cerr_q, cerr_d, aerr_q, aerr_d;
    logic hit, changed, onehot, accept, frame;

    assign sel = ~in_q[10:7];
    assign changed = in_q != prev_q;
    assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign frame = vld_q == 4'hF;

    seg_to_hex u_lut (.seg_i(in_q[6:0]), .nibble(nibble), .hit(hit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= IN_RST;
            prev_q <= IN_RST;
            state_q <= IDLE;
            cnt_q <= '0;
            val_q <= '0;
            vld_q <= '0;
            frame_q <= '0;
            fv_q <= 1'b0;
            cerr_q <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            in_q <= {bus_io.an, bus_io.seg};
            prev_q <= in_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            val_q <= val_d;
            vld_q <= vld_d;
            frame_q <= frame_d;
            fv_q <= fv_d;
            cerr_q <= cerr_d;
            aerr_q <= aerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        accept = 1'b0;
        if (changed) begin
            cnt_d = '0;
            state_d = sel == 4'd0 ? IDLE : (onehot ? SETTLE : MULTI);
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = LOCKED;
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fv_d = frame;
        frame_d = frame ? val_q : frame_q;
        cerr_d = accept && !hit;
        aerr_d = changed && state_d == MULTI && state_q != MULTI;
        // frame clear first, then any new capture
        vld_d = (frame ? 4'h0 : vld_q) | ((accept && hit) ? sel : 4'h0);
        val_d = val_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && hit && sel[i]) val_d[4*i +: 4] = nibble;
        end
    end

    assign bus_io.digit_value = val_q;
    assign bus_io.digit_valid = vld_q;
    assign bus_io.frame_value = frame_q;
    assign bus_io.frame_valid = fv_q;
    assign bus_io.code_err = cerr_q;
    assign bus_io.an_err = aerr_q;
endmodule

// File: tb/tb_seg_pattern_reader.sv
// tb_seg_pattern_reader: table-driven directed vectors plus toggle and reset sequences
module tb_seg_pattern_reader;
    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] val;
        logic [3:0]  vld;
        logic [15:0] frm;
        int          cerr;
        int          aerr;
        int          fv;
    } vec_t;

    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int cerr_n = 0, aerr_n = 0, fv_n = 0;
    int c0, a0, f0;
    vec_t vecs[NV];

    seg_pattern_reader_if bus();
    seg_pattern_reader #(.STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cerr_n <= cerr_n + int'(bus.code_err);
        aerr_n <= aerr_n + int'(bus.an_err);
        fv_n <= fv_n + int'(bus.frame_valid);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] val, input logic [3:0] vld,
                           input logic [15:0] frm, input int ce, input int ae, input int fv);
        chk({tag, " digit_value"}, 32'(bus.digit_value), 32'(val));
        chk({tag, " digit_valid"}, 32'(bus.digit_valid), 32'(vld));
        chk({tag, " frame_value"}, 32'(bus.frame_value), 32'(frm));
        chk({tag, " code_err pulses"}, 32'(cerr_n - c0), 32'(ce));
        chk({tag, " an_err pulses"}, 32'(aerr_n - a0), 32'(ae));
        chk({tag, " frame_valid pulses"}, 32'(fv_n - f0), 32'(fv));
    endtask

    task automatic mark();
        c0 = cerr_n;
        a0 = aerr_n;
        f0 = fv_n;
    endtask

    initial begin
        vecs[0]  = '{4'hE, 7'b0110000, 4,  16'h0000, 4'b0000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{4'hE, 7'b0110000, 1,  16'h0003, 4'b0001, 16'h0000, 0, 0, 0};
        vecs[2]  = '{4'hE, 7'b1111001, 6,  16'h0001, 4'b0001, 16'h0000, 0, 0, 0};
        vecs[3]  = '{4'hD, 7'b0100100, 6,  16'h0021, 4'b0011, 16'h0000, 0, 0, 0};
        vecs[4]  = '{4'hB, 7'b0001000, 6,  16'h0A21, 4'b0111, 16'h0000, 0, 0, 0};
        vecs[5]  = '{4'h7, 7'b0001110, 6,  16'hFA21, 4'b0000, 16'hFA21, 0, 0, 1};
        vecs[6]  = '{4'hE, 7'b0010010, 6,  16'hFA25, 4'b0001, 16'hFA21, 0, 0, 0};
        vecs[7]  = '{4'hE, 7'b1111111, 6,  16'hFA25, 4'b0001, 16'hFA21, 1, 0, 0};
        vecs[8]  = '{4'hC, 7'b0000000, 10, 16'hFA25, 4'b0001, 16'hFA21, 0, 1, 0};
        vecs[9]  = '{4'hF, 7'b1111111, 6,  16'hFA25, 4'b0001, 16'hFA21, 0, 0, 0};
        vecs[10] = '{4'hD, 7'b0010000, 20, 16'hFA95, 4'b0011, 16'hFA21, 0, 0, 0};
        vecs[11] = '{4'hB, 7'b1000110, 6,  16'hFC95, 4'b0111, 16'hFA21, 0, 0, 0};
        vecs[12] = '{4'h7, 7'b0100001, 6,  16'hDC95, 4'b0000, 16'hDC95, 0, 0, 1};
        vecs[13] = '{4'hE, 7'b0000000, 6,  16'hDC98, 4'b0001, 16'hDC95, 0, 0, 0};

        bus.an = 4'hF;
        bus.seg = 7'h7F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        mark();
        chk_all("reset", 16'h0, 4'h0, 16'h0, 0, 0, 0);
        chk("reset frame_valid", 32'(bus.frame_valid), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            mark();
            bus.an = vecs[v].an;
            bus.seg = vecs[v].seg;
            repeat (vecs[v].hold) @(posedge clk);
            @(negedge clk);
            #1;
            chk_all($sformatf("vec%0d", v), vecs[v].val, vecs[v].vld, vecs[v].frm,
                    vecs[v].cerr, vecs[v].aerr, vecs[v].fv);
        end

        // pattern changing every 3 cycles never settles
        mark();
        for (int k = 0; k < 10; k++) begin
            bus.an = 4'hB;
            bus.seg = (k % 2 == 0) ? 7'b1111000 : 7'b0000010;
            repeat (3) @(posedge clk);
            #1;
        end
        bus.an = 4'hF;
        bus.seg = 7'h7F;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all("toggle", 16'hDC98, 4'b0001, 16'hDC95, 0, 0, 0);

        // reset in the middle of SETTLE discards progress
        bus.an = 4'hE;
        bus.seg = 7'b0011001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        mark();
        chk_all("async reset", 16'h0, 4'h0, 16'h0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("post-reset edge4 digit_valid", 32'(bus.digit_valid), 32'h0);
        chk("post-reset edge4 digit_value", 32'(bus.digit_value), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post-reset edge5 digit_valid", 32'(bus.digit_valid), 32'h1);
        chk("post-reset edge5 digit_value", 32'(bus.digit_value), 32'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_pattern_reader.md
SEG_PATTERN_READER -- requirements
Module: seg_pattern_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive cycles a pattern must hold before acceptance; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 seg  input  7  segment lines, active-low (0 = lit), bit order g..a, matching the team's hex-to-7-segment encoding.
REQ-005 an  input  4  digit enables, active-low; an[i]=0 selects digit i.
REQ-006 digit_value  output  16  captured nibbles, digit i at bits [4i+3:4i].
REQ-007 digit_valid  output  4  bit i set when digit i has been captured in the current frame.
REQ-008 frame_value  output  16  snapshot of digit_value at frame completion.
REQ-009 frame_valid  output  1  one-cycle pulse when frame_value updates.
REQ-010 code_err  output  1  one-cycle pulse when a stable pattern is not one of the 16 hex glyphs.
REQ-011 an_err  output  1  one-cycle pulse on entry to a state with more than one anode low.

Function
REQ-012 The block shall register {an, seg} once at the input; all decisions use the registered value.
REQ-013 The FSM shall have states IDLE (an = 4'b1111), SETTLE (one-hot-low an, counting) and LOCKED (pattern accepted, waiting for change).
REQ-014 Any change of registered {an, seg} shall clear the stability counter and enter SETTLE, IDLE, or the multi-anode condition, as an dictates.
REQ-015 In SETTLE, the counter shall increment each cycle the pattern is unchanged; it shall be sized for STABLE_CYCLES and shall never wrap.
REQ-016 Acceptance shall occur on the (STABLE_CYCLES+1)th rising edge, counting the first edge that samples the new pattern as edge 1, provided {an, seg} held throughout; the FSM then enters LOCKED.
REQ-017 On acceptance of a valid glyph, the block shall write the nibble into digit i and set digit_valid[i]; an already-set digit shall be overwritten without error.
REQ-018 On acceptance of a non-glyph pattern, including blank 7'b111_1111, the block shall pulse code_err and leave digit_value and digit_valid unchanged.
REQ-019 In LOCKED, the block shall not re-accept until {an, seg} changes.
REQ-020 Multiple low anodes shall cause an_err once on entry and no capture; the counter shall be held at 0 until an becomes legal.
REQ-021 The cycle after digit_valid becomes 4'b1111, the block shall pulse frame_valid, load frame_value from digit_value, and clear digit_valid.
REQ-022 If an acceptance coincides with the frame_valid cycle, the clear shall apply first and the new digit_valid bit shall then be set.
REQ-023 Glyph table (active-low): 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.

Reset
REQ-024 Asserting rst shall immediately force IDLE, counter 0, input register {4'b1111, 7'b111_1111}, and all outputs 0.
REQ-025 Reset mid-SETTLE or mid-frame shall discard partial progress; after release, a pattern needs the full STABLE_CYCLES again.

Structure
REQ-026 Glyph constants SEG_0..SEG_F and SEG_BLANK, and the FSM state encoding, shall live in shared package seg_pkg, reused by the existing hex decoder.
REQ-027 The inverse lookup shall be a combinational sub-module seg_to_hex with outputs nibble[3:0] and hit; it shall be the only lookup used.

Verification
REQ-028 Scenario: an=1110, seg=011_0000 held 5 cycles (STABLE_CYCLES=4) -> after edge 5, digit_value[3:0]=3 and digit_valid=0001; no update at edge 4.
REQ-029 Scenario: digits 0..3 driven with 1, 2, A, F, each held 6 cycles -> one frame_valid pulse, frame_value=16'hFA21, digit_valid=0000 next cycle.
REQ-030 Scenario: an=1110 with seg=111_1111 held 6 cycles -> exactly one code_err pulse, digit_valid unchanged.
REQ-031 Scenario: an=1100 for 10 cycles -> exactly one an_err pulse, no capture.
REQ-032 Scenario: pattern toggled every 3 cycles for 30 cycles -> no capture and no error.
REQ-033 Scenario: rst asserted at cycle 2 of SETTLE, then released with the pattern unchanged -> capture only after a full 5 edges post-release.
